// File: rtl/hbridge_pwm_multi_if.sv
// Register-file side bundle of the multi-channel H-bridge PWM stage.
// The register file drives the master side; the PWM core takes the slave side.
interface hbridge_pwm_multi_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int DEAD_W   = 4
);
    logic                      pwm_en;
    logic                      load;
    logic [CHANNELS*WIDTH-1:0] duty_in;
    logic [CHANNELS*2-1:0]     mode_in;
    logic [DEAD_W-1:0]         dead_cycles;
    logic [CHANNELS-1:0]       motor_positive;
    logic [CHANNELS-1:0]       motor_negative;
    logic                      period_start;

    modport master (
        output pwm_en, load, duty_in, mode_in, dead_cycles,
        input  motor_positive, motor_negative, period_start
    );

    modport slave (
        input  pwm_en, load, duty_in, mode_in, dead_cycles,
        output motor_positive, motor_negative, period_start
    );
endinterface

// File: rtl/hbridge_pwm_multi.sv
// Multi-channel H-bridge PWM: shared period counter, double-buffered duty/mode
// per channel, dead time on mode changes, registered pin outputs.
module hbridge_pwm_multi #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int DEAD_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    hbridge_pwm_multi_if.slave  bus
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'((1 << WIDTH) - 2);

    typedef enum logic [1:0] {
        COAST = 2'b00,
        FWD   = 2'b01,
        REV   = 2'b10,
        BRAKE = 2'b11
    } mode_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             en_q;
    logic             ps_q, ps_d;
    logic             start, wrap, upd;
    logic [CHANNELS-1:0] pos_v, neg_v;

    // en_q marks that the counter is running; the first enabled edge only
    // restarts the period at cnt 0 so period_start lines up with cnt == 0.
    assign start = bus.pwm_en && !en_q;
    assign wrap  = bus.pwm_en && en_q && (cnt_q == LAST);
    assign upd   = wrap || start || !bus.pwm_en;

    always_comb begin
        cnt_d = cnt_q;
        ps_d  = 1'b0;
        if (!bus.pwm_en) begin
            cnt_d = '0;
        end else if (start || wrap) begin
            cnt_d = '0;
            ps_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
            ps_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= bus.pwm_en;
            ps_q  <= ps_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0]  sh_duty_q, sh_duty_d, act_duty_q;
        mode_e             sh_mode_q, sh_mode_d, act_mode_q;
        logic [DEAD_W-1:0] dead_q, dead_d;
        logic              pos_q, neg_q, pos_d, neg_d, raw;

        always_comb begin
            sh_duty_d = bus.load ? bus.duty_in[k*WIDTH +: WIDTH] : sh_duty_q;
            sh_mode_d = bus.load ? mode_e'(bus.mode_in[2*k +: 2]) : sh_mode_q;

            // A mode change at a wrap (re)loads the gap; otherwise any running
            // gap keeps draining, even across period boundaries.
            dead_d = dead_q;
            if (!bus.pwm_en || start)
                dead_d = '0;
            else if (wrap && (sh_mode_d != act_mode_q) && (bus.dead_cycles != '0))
                dead_d = bus.dead_cycles;
            else if (dead_q != '0)
                dead_d = dead_q - 1'b1;

            raw   = (cnt_q < act_duty_q);
            pos_d = 1'b0;
            neg_d = 1'b0;
            if (bus.pwm_en && en_q && (dead_q == '0)) begin
                case (act_mode_q)
                    FWD:     pos_d = raw;
                    REV:     neg_d = raw;
                    BRAKE:   begin pos_d = 1'b1; neg_d = 1'b1; end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sh_duty_q  <= '0;
                sh_mode_q  <= COAST;
                act_duty_q <= '0;
                act_mode_q <= COAST;
                dead_q     <= '0;
                pos_q      <= 1'b0;
                neg_q      <= 1'b0;
            end else begin
                sh_duty_q <= sh_duty_d;
                sh_mode_q <= sh_mode_d;
                // Taking the shadow's next value lets a load on the wrap edge
                // land directly in the coming period.
                if (upd) begin
                    act_duty_q <= sh_duty_d;
                    act_mode_q <= sh_mode_d;
                end
                dead_q <= dead_d;
                pos_q  <= pos_d;
                neg_q  <= neg_d;
            end
        end

        assign pos_v[k] = pos_q;
        assign neg_v[k] = neg_q;
    end

    assign bus.motor_positive = pos_v;
    assign bus.motor_negative = neg_v;
    assign bus.period_start   = ps_q;
endmodule

// File: tb/tb_hbridge_pwm_multi.sv
// Directed bench for hbridge_pwm_multi (2 channels, WIDTH=4, 15-cycle period)
// with a queue of expected per-cycle pin states.
module tb_hbridge_pwm_multi;
    localparam int CH = 2;
    localparam int W  = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [1:0] pos;
        logic [1:0] neg;
        logic       ps;
    } exp_t;
    exp_t sb[$];

    hbridge_pwm_multi_if #(.CHANNELS(CH), .WIDTH(W), .DEAD_W(DW)) bus ();

    hbridge_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .DEAD_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {neg,pos} for one channel in the output cycle that reflects counter value i
    function automatic logic [1:0] exp_pin(input logic [1:0] m, input int d,
                                           input int dc, input int i);
        if (i < dc) return 2'b00;
        case (m)
            2'b01:   return {1'b0, i < d};
            2'b10:   return {i < d, 1'b0};
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Starting at a sample point where cnt == 0, run n cycles expecting the given
    // active mode/duty/dead-gap per channel; optionally pulse load at cnt == ld_at.
    task automatic run(input string tag,
                       input logic [1:0] m0, input int d0, input int dc0,
                       input logic [1:0] m1, input int d1, input int dc1,
                       input int n, input int ld_at);
        logic [1:0] e0, e1;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e0 = exp_pin(m0, d0, dc0, i);
            e1 = exp_pin(m1, d1, dc1, i);
            sb.push_back('{pos: {e1[0], e0[0]}, neg: {e1[1], e0[1]}, ps: (i == 14)});
        end
        for (int i = 0; i < n; i++) begin
            if (i == ld_at) bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            e = sb.pop_front();
            chk($sformatf("%s_pos[%0d]", tag, i), {2'b00, bus.motor_positive}, {2'b00, e.pos});
            chk($sformatf("%s_neg[%0d]", tag, i), {2'b00, bus.motor_negative}, {2'b00, e.neg});
            chk($sformatf("%s_ps[%0d]", tag, i), {3'b000, bus.period_start}, {3'b000, e.ps});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pwm_en      = 1'b1;
        bus.load        = 1'b0;
        bus.duty_in     = '0;
        bus.mode_in     = '0;
        bus.dead_cycles = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pos", {2'b00, bus.motor_positive}, 4'h0);
        chk("rst_neg", {2'b00, bus.motor_negative}, 4'h0);
        chk("rst_ps", {3'b000, bus.period_start}, 4'h0);
        rst = 1'b0;
        tick();
        chk("first_ps", {3'b000, bus.period_start}, 4'h1);
        chk("first_pos", {2'b00, bus.motor_positive}, 4'h0);

        run("idle", 2'b00, 0, 0, 2'b00, 0, 0, 15, -1);

        bus.duty_in = {4'd7, 4'd5};
        bus.mode_in = {2'b00, 2'b01};
        run("fwd_ld", 2'b00, 0, 0, 2'b00, 0, 0, 15, 3);
        run("fwd", 2'b01, 5, 0, 2'b00, 7, 0, 15, -1);

        bus.duty_in = {4'd0, 4'd0};
        bus.mode_in = {2'b11, 2'b10};
        run("fwd2", 2'b01, 5, 0, 2'b00, 7, 0, 15, 5);
        run("ext_d0", 2'b10, 0, 0, 2'b11, 0, 0, 15, -1);

        bus.duty_in = {4'd9, 4'd15};
        run("ext_d0b", 2'b10, 0, 0, 2'b11, 0, 0, 15, 7);
        run("ext_d15", 2'b10, 15, 0, 2'b11, 9, 0, 15, -1);

        bus.mode_in = {2'b11, 2'b01};
        run("ext_b", 2'b10, 15, 0, 2'b11, 9, 0, 15, 2);
        run("dt_pre", 2'b01, 15, 0, 2'b11, 9, 0, 15, -1);

        bus.dead_cycles = 4'd3;
        bus.mode_in     = {2'b11, 2'b10};
        run("dt_pre2", 2'b01, 15, 0, 2'b11, 9, 0, 15, 4);
        run("dead", 2'b10, 15, 3, 2'b11, 9, 0, 15, 9);
        run("same", 2'b10, 15, 0, 2'b11, 9, 0, 15, -1);

        bus.duty_in = {4'd9, 4'd9};
        run("same_wl", 2'b10, 15, 0, 2'b11, 9, 0, 15, 14);
        run("wrap_ld", 2'b10, 9, 0, 2'b11, 9, 0, 15, -1);
        run("pre_dis", 2'b10, 9, 0, 2'b11, 9, 0, 6, -1);

        bus.pwm_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus.duty_in = {4'd9, 4'd4};
                bus.mode_in = {2'b11, 2'b01};
                bus.load    = 1'b1;
            end
            tick();
            bus.load = 1'b0;
            chk($sformatf("dis_pos[%0d]", i), {2'b00, bus.motor_positive}, 4'h0);
            chk($sformatf("dis_neg[%0d]", i), {2'b00, bus.motor_negative}, 4'h0);
            chk($sformatf("dis_ps[%0d]", i), {3'b000, bus.period_start}, 4'h0);
        end

        bus.pwm_en = 1'b1;
        tick();
        chk("reen_ps", {3'b000, bus.period_start}, 4'h1);
        chk("reen_pos0", {2'b00, bus.motor_positive}, 4'h0);
        run("reen", 2'b01, 4, 0, 2'b11, 9, 0, 15, -1);

        tick();
        chk("hi_pos", {2'b00, bus.motor_positive}, 4'h3);
        #2 rst = 1'b1;
        #1;
        chk("arst_pos", {2'b00, bus.motor_positive}, 4'h0);
        chk("arst_neg", {2'b00, bus.motor_negative}, 4'h0);
        chk("arst_ps", {3'b000, bus.period_start}, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hbridge_pwm_multi.md
# hbridge_pwm_multi

Parametrised multi-channel H-bridge PWM generator, next generation of the single-channel motor output stage inside the ESC. It drives `CHANNELS` motor pin pairs from one shared period counter. Each channel has a direction/brake mode and double-buffered duty and mode registers that update only at period boundaries. Programmable dead time is inserted on every mode change. The block sits between the I2C register file and the `motor_positive`/`motor_negative` pads.

## Interface
Parameters:
- `CHANNELS`, 2: number of independent H-bridge channels.
- `WIDTH`, 8: duty/counter width. Period is `MAX = 2^WIDTH - 1` cycles.
- `DEAD_W`, 4: width of the dead-time setting.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pwm_en` in 1: global enable.
- `load` in 1: strobe that captures `duty_in`/`mode_in` into the shadow registers, all channels.
- `duty_in` in `CHANNELS*WIDTH`: per-channel duty. Channel k uses `[k*WIDTH +: WIDTH]`.
- `mode_in` in `CHANNELS*2`: per-channel mode. Channel k uses `[2k +: 2]`. Encoding: 00 coast, 01 forward, 10 reverse, 11 brake.
- `dead_cycles` in `DEAD_W`: dead-time length in clocks. Sampled at each active update.
- `motor_positive` out `CHANNELS`: high-side A per channel, registered.
- `motor_negative` out `CHANNELS`: high-side B per channel, registered.
- `period_start` out 1: one-cycle pulse, high while `cnt == 0` following a wrap or enable.

## Operation
- **Reset values:** `cnt` 0; shadow and active duty 0; shadow and active mode 00; dead counters 0; all outputs 0; `period_start` 0.
- **Counter:**
  - When `pwm_en` = 1: `cnt` counts 0..MAX-1, then wraps to 0.
  - When `pwm_en` = 0: `cnt` is held at 0.
- **Wrap event:** `pwm_en && cnt == MAX-1`. At that edge:
  - `cnt` goes to 0.
  - Active duty and mode are loaded from the shadow registers.
  - `period_start` goes to 1.
- **Shadow:** `load` = 1 captures the inputs at the edge.
  - If `load` coincides with a wrap, the active registers take `duty_in`/`mode_in` directly, so the new values apply to the next period.
  - `load` at any other time never affects the current period.
- **Compare:** `pwm_raw[k] = (cnt < duty_k)`, unsigned WIDTH-bit compare.
  - duty 0 gives 0% on.
  - duty MAX gives 100% on.
- **Output mapping** (registered, per channel):
  - coast → `pos`=0, `neg`=0.
  - forward → `pos`=`pwm_raw`, `neg`=0.
  - reverse → `pos`=0, `neg`=`pwm_raw`.
  - brake → `pos`=1, `neg`=1, independent of duty.
- **Dead time:**
  - Trigger: at an active update where channel k's new mode ≠ its old active mode and `dead_cycles` ≠ 0.
  - `dead_cnt[k]` is loaded with `dead_cycles`.
  - While `dead_cnt[k]` ≠ 0, channel k outputs 00 and `dead_cnt[k]` decrements by 1 per clock.
  - An unchanged mode never triggers dead time.
  - Dead time longer than a period continues across the wrap. A further mode change at that wrap reloads the counter.
- **Disable (`pwm_en` = 0):**
  - Outputs are forced 00 from the next edge.
  - Active registers follow the shadow every cycle.
  - Dead counters are cleared.
- **Re-enable:**
  - On the first enabled cycle `cnt` = 0 and `period_start` = 1.
  - Outputs use the current shadow values with no dead time.
- **Reset mid-operation:** all state returns to reset values asynchronously, and outputs drop to 0 immediately.

## Timing
- Output latency: the outputs at edge t+1 reflect `cnt`, active registers and `dead_cnt` at cycle t, i.e. one clock behind the counter.
- Period: exactly MAX clocks between consecutive `period_start` pulses while enabled.
- Duty change latency: active from the first `cnt == 0` after `load`. The output reflects it one clock later.
- Dead time: exactly `dead_cycles` output cycles of 00, starting with the first output cycle of the new period.
- No combinational path from any input to any output.

## Test plan
- **Reset/period:** WIDTH=4, `pwm_en`=1, no load. Hold `rst` 3 cycles, release → all outputs 0; `period_start` pulses every 15 clocks, first pulse on the first cycle after release.
- **Forward duty:** WIDTH=4, ch0 `duty_in`=5, mode 01, pulse `load` → from the next period, `motor_positive[0]` is high exactly 5 of 15 cycles, starting 1 clock after `period_start`; `motor_negative[0]`=0; ch1 unaffected.
- **Extremes:**
  - duty 0, mode 10 → `neg` never high.
  - duty 15, mode 10 → `neg` constantly high.
  - mode 11 → both pins 1 for any duty.
- **Dead time:** ch0 duty 15, forward, then load reverse with `dead_cycles`=3 → first 3 output cycles of the new period are 00, then `neg`=1, `pos`=0. Reloading the same mode gives no 00 gap.
- **Load at wrap:** assert `load` with duty 9 in the cycle `cnt` = 14 → the immediately following period shows 9 high cycles.
- **Disable/reset mid-period:**
  - Drop `pwm_en` at `cnt` = 6 → outputs 00 next edge, `cnt` held 0; re-enable → `period_start` on the first enabled cycle.
  - Assert `rst` asynchronously mid-high-phase → outputs 0 before the next clock edge.
